accelerator_bus_scheduler: RTL

Time-shares the 128-bit router data bus among the FFT, FIR and IIR accelerators by driving the one-hot `fft_enable` / `fir_enable` / `iir_enable` inputs of `data_bus_controller`. It arbitrates round-robin among accelerators that have FIFO work pending and bounds each tenure to `BURST_LEN` cycles. Between tenures it inserts guaranteed all-disabled turnaround cycles, so no two tri-state drivers overlap on the bus.

---
 rtl/acc_sched_pkg.sv | 18 +
 rtl/accelerator_bus_scheduler_rr_pick3.sv | 60 ++++++
 rtl/accelerator_bus_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/acc_sched_pkg.sv
// Shared types and constants for the accelerator bus scheduler.
// Provides the FSM state encoding, accelerator IDs and accelerator count.
package acc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    localparam logic [1:0] ACC_FFT  = 2'd0;
    localparam logic [1:0] ACC_FIR  = 2'd1;
    localparam logic [1:0] ACC_IIR  = 2'd2;
    localparam logic [1:0] ACC_NONE = 2'd3;

    localparam int NUM_ACC = 3;

endpackage

// File: rtl/accelerator_bus_scheduler_rr_pick3.sv
// Combinational 3-way round-robin picker.
// Ports: need_i[2:0], last_i[1:0] -> winner_o[1:0], valid_o.
module rr_pick3
    import acc_sched_pkg::*;
(
    input  logic [2:0] need_i,
    input  logic [1:0] last_i,
    output logic [1:0] winner_o,
    output logic       valid_o
);

    logic [1:0] o0, o1, o2;
    logic       n0, n1, n2;

    // Search order starts just after the last winner.
    always_comb begin
        case (last_i)
            ACC_FFT: begin
                o0 = ACC_FIR;
                o1 = ACC_IIR;
                o2 = ACC_FFT;
                n0 = need_i[1];
                n1 = need_i[2];
                n2 = need_i[0];
            end
            ACC_FIR: begin
                o0 = ACC_IIR;
                o1 = ACC_FFT;
                o2 = ACC_FIR;
                n0 = need_i[2];
                n1 = need_i[0];
                n2 = need_i[1];
            end
            default: begin
                o0 = ACC_FFT;
                o1 = ACC_FIR;
                o2 = ACC_IIR;
                n0 = need_i[0];
                n1 = need_i[1];
                n2 = need_i[2];
            end
        endcase
    end

    always_comb begin
        winner_o = ACC_NONE;
        valid_o  = 1'b0;
        if (n0) begin
            winner_o = o0;
            valid_o  = 1'b1;
        end else if (n1) begin
            winner_o = o1;
            valid_o  = 1'b1;
        end else if (n2) begin
            winner_o = o2;
            valid_o  = 1'b1;
        end
    end

endmodule

// File: rtl/accelerator_bus_scheduler.sv
// Round-robin, burst-bounded bus scheduler for FFT/FIR/IIR accelerators.
// In: clk, rst_n, acc_active[2:0], per-accelerator FIFO full/empty flags.
// Out: one-hot registered enables, grant_id[1:0] (3 = none), busy.
module accelerator_bus_scheduler
    import acc_sched_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int GAP       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] acc_active,
    input  logic       to_fft_full,
    input  logic       from_fft_empty,
    input  logic       to_fir_full,
    input  logic       from_fir_empty,
    input  logic       to_iir_full,
    input  logic       from_iir_empty,
    output logic       fft_enable,
    output logic       fir_enable,
    output logic       iir_enable,
    output logic [1:0] grant_id,
    output logic       busy
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_e          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [3:0]      gap_q, gap_d;
    logic [2:0]      en_q, en_d;
    logic [1:0]      gid_q, gid_d;
    logic            busy_q, busy_d;

    logic [NUM_ACC-1:0] need;
    logic [1:0]         pick;
    logic               pick_vld;
    logic               own_need;
    logic               rel;

    assign need[0] = acc_active[0] & (~to_fft_full | ~from_fft_empty);
    assign need[1] = acc_active[1] & (~to_fir_full | ~from_fir_empty);
    assign need[2] = acc_active[2] & (~to_iir_full | ~from_iir_empty);

    rr_pick3 u_pick (
        .need_i   (need),
        .last_i   (last_q),
        .winner_o (pick),
        .valid_o  (pick_vld)
    );

    // need already folds in acc_active, so one term covers both
    // the drained-FIFO and the host-deactivated release causes.
    always_comb begin
        case (owner_q)
            ACC_FFT: own_need = need[0];
            ACC_FIR: own_need = need[1];
            ACC_IIR: own_need = need[2];
            default: own_need = 1'b0;
        endcase
    end

    assign rel = (beat_q == BW'(BURST_LEN - 1)) | ~own_need;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    owner_d = pick;
                    last_d  = pick;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_d = TURN;
                    owner_d = ACC_NONE;
                    gap_d   = 4'(GAP - 1);
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            TURN: begin
                if (gap_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = ACC_NONE;
            end
        endcase
    end

    // Outputs are decoded from next state so they land in flops
    // on the same edge as the FSM transition.
    always_comb begin
        en_d   = 3'b000;
        gid_d  = ACC_NONE;
        busy_d = (state_d != IDLE);
        if (state_d == GRANT) begin
            gid_d = owner_d;
            case (owner_d)
                ACC_FFT: en_d = 3'b001;
                ACC_FIR: en_d = 3'b010;
                ACC_IIR: en_d = 3'b100;
                default: en_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= ACC_NONE;
            last_q  <= ACC_IIR;
            beat_q  <= '0;
            gap_q   <= 4'd0;
            en_q    <= 3'b000;
            gid_q   <= ACC_NONE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
        end
    end

    assign fft_enable = en_q[0];
    assign fir_enable = en_q[1];
    assign iir_enable = en_q[2];
    assign grant_id   = gid_q;
    assign busy       = busy_q;

endmodule
